// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin arbiter sharing one registered writeback port among execution units
module wb_arbiter #(
    parameter int NREQ  = 3,
    parameter int REGW  = 5,
    parameter int DATAW = 32,
    localparam int SW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*REGW-1:0]  req_rd,
    input  logic [NREQ*DATAW-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  freeze,
    output logic                  wb_valid,
    output logic [REGW-1:0]       wb_rd,
    output logic [DATAW-1:0]      wb_data,
    output logic [SW-1:0]         wb_src,
    output logic                  busy
);
    logic [SW-1:0]    ptr_q, ptr_d, gnt_idx;
    logic             any_req, xfer;
    logic             wb_valid_q, wb_valid_d;
    logic [REGW-1:0]  wb_rd_q, wb_rd_d;
    logic [DATAW-1:0] wb_data_q, wb_data_d;
    logic [SW-1:0]    wb_src_q, wb_src_d;

    // pick the first valid requester scanning from ptr upward with wrap
    always_comb begin
        int j;
        j = 0;
        gnt_idx = '0;
        any_req = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = int'(ptr_q) + k;
            if (j >= NREQ) j = j - NREQ;
            if (req_valid[j]) begin
                any_req = 1'b1;
                gnt_idx = SW'(j);
            end
        end
    end

    // accept a beat unless stalled or in reset; advance pointer past the winner
    always_comb begin
        xfer       = any_req & ~freeze & nRST;
        req_ready  = xfer ? (NREQ'(1) << gnt_idx) : '0;
        ptr_d      = xfer ? ((int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1) : ptr_q;
        wb_valid_d = freeze ? wb_valid_q : xfer;
        wb_rd_d    = xfer ? req_rd[gnt_idx*REGW +: REGW] : wb_rd_q;
        wb_data_d  = xfer ? req_data[gnt_idx*DATAW +: DATAW] : wb_data_q;
        wb_src_d   = xfer ? gnt_idx : wb_src_q;
    end

    // output beat and pointer registers; reset discards any in-flight beat
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ptr_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            wb_src_q   <= '0;
        end else begin
            ptr_q      <= ptr_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            wb_src_q   <= wb_src_d;
        end
    end

    assign wb_valid = wb_valid_q;
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;
    assign wb_src   = wb_src_q;
    assign busy     = (|req_valid) | wb_valid_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed checks of grant order, latency, freeze and reset behaviour
module tb_wb_arbiter;
    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic [2:0]  req_valid = '0;
    logic [14:0] req_rd = '0;
    logic [95:0] req_data = '0;
    logic [2:0]  req_ready;
    logic        freeze = 1'b0;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [1:0]  wb_src;
    logic        busy;
    int vectors = 0;
    int miscompares = 0;

    wb_arbiter dut (
        .CLK(CLK), .nRST(nRST), .req_valid(req_valid), .req_rd(req_rd),
        .req_data(req_data), .req_ready(req_ready), .freeze(freeze),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_src(wb_src), .busy(busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        #2;
        nRST = 1'b1;
        #1;
    endtask

    task automatic beat(input string tag, input logic [1:0] src, input logic [4:0] rd, input logic [31:0] data);
        chk({tag, "_valid"}, 64'(wb_valid), 64'd1);
        chk({tag, "_src"}, 64'(wb_src), 64'(src));
        chk({tag, "_rd"}, 64'(wb_rd), 64'(rd));
        chk({tag, "_data"}, 64'(wb_data), 64'(data));
    endtask

    initial begin
        #1;
        // reset state, with a request pending during reset
        req_valid = 3'b001;
        #1;
        chk("rst_valid", 64'(wb_valid), 64'd0);
        chk("rst_rd", 64'(wb_rd), 64'd0);
        chk("rst_data", 64'(wb_data), 64'd0);
        chk("rst_src", 64'(wb_src), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd1);
        req_valid = 3'b000;
        #10;
        nRST = 1'b1;
        tick();
        chk("idle_busy", 64'(busy), 64'd0);

        // single request
        req_valid = 3'b001;
        req_rd    = {5'd0, 5'd0, 5'd5};
        req_data  = {32'd0, 32'd0, 32'hDEAD};
        #1;
        chk("single_ready", 64'(req_ready), 64'b001);
        tick();
        req_valid = 3'b000;
        beat("single", 2'd0, 5'd5, 32'hDEAD);
        tick();
        chk("single_after", 64'(wb_valid), 64'd0);
        chk("single_hold_rd", 64'(wb_rd), 64'd5);

        // contention: round-robin 0,1,2,0,1,2 with back-to-back beats
        do_reset();
        req_valid = 3'b111;
        req_rd    = {5'd3, 5'd2, 5'd1};
        req_data  = {32'd30, 32'd20, 32'd10};
        for (int c = 0; c < 6; c++) begin
            #1;
            chk("cont_ready", 64'(req_ready), 64'(3'b001 << (c % 3)));
            if (c > 0) beat("cont", 2'((c - 1) % 3), 5'((c - 1) % 3 + 1), 32'(((c - 1) % 3 + 1) * 10));
            tick();
        end
        req_valid = 3'b000;
        beat("cont_last", 2'd2, 5'd3, 32'd30);
        tick();
        chk("cont_end", 64'(wb_valid), 64'd0);

        // wrap-around: grant 2 first, then 0,1,2
        do_reset();
        req_valid = 3'b100;
        #1;
        chk("wrap_first", 64'(req_ready), 64'b100);
        tick();
        beat("wrap_b2", 2'd2, 5'd3, 32'd30);
        req_valid = 3'b111;
        #1;
        chk("wrap_g0", 64'(req_ready), 64'b001);
        tick();
        #1;
        chk("wrap_g1", 64'(req_ready), 64'b010);
        tick();
        #1;
        chk("wrap_g2", 64'(req_ready), 64'b100);
        tick();
        beat("wrap_last", 2'd2, 5'd3, 32'd30);

        // freeze: nothing accepted, outputs and pointer held
        req_valid = 3'b011;
        freeze = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("frz_ready", 64'(req_ready), 64'd0);
            tick();
            beat("frz_hold", 2'd2, 5'd3, 32'd30);
        end
        freeze = 1'b0;
        #1;
        chk("frz_rel_g0", 64'(req_ready), 64'b001);
        tick();
        beat("frz_b0", 2'd0, 5'd1, 32'd10);
        req_valid = 3'b010;
        #1;
        chk("frz_rel_g1", 64'(req_ready), 64'b010);
        tick();
        req_valid = 3'b000;
        beat("frz_b1", 2'd1, 5'd2, 32'd20);
        tick();
        chk("frz_end", 64'(wb_valid), 64'd0);

        // reset mid-beat: pointer is 2 here, grant 2 then abort its beat
        req_valid = 3'b100;
        #1;
        chk("abort_grant", 64'(req_ready), 64'b100);
        tick();
        nRST = 1'b0;
        #1;
        chk("abort_valid", 64'(wb_valid), 64'd0);
        chk("abort_data", 64'(wb_data), 64'd0);
        chk("abort_ready", 64'(req_ready), 64'd0);
        chk("abort_busy", 64'(busy), 64'd1);
        req_valid = 3'b000;
        #1;
        nRST = 1'b1;
        tick();
        chk("abort_nobeat", 64'(wb_valid), 64'd0);
        req_valid = 3'b111;
        #1;
        chk("abort_ptr0", 64'(req_ready), 64'b001);
        req_valid = 3'b000;
        tick();
        tick();

        // same destination register, beats in grant order
        do_reset();
        req_valid = 3'b011;
        req_rd    = {5'd0, 5'd7, 5'd7};
        req_data  = {32'd0, 32'd2, 32'd1};
        #1;
        chk("same_g0", 64'(req_ready), 64'b001);
        tick();
        beat("same_b0", 2'd0, 5'd7, 32'd1);
        req_valid = 3'b010;
        #1;
        chk("same_g1", 64'(req_ready), 64'b010);
        tick();
        req_valid = 3'b000;
        beat("same_b1", 2'd1, 5'd7, 32'd2);
        chk("same_busy_hi", 64'(busy), 64'd1);
        tick();
        chk("same_done", 64'(wb_valid), 64'd0);
        chk("same_busy_lo", 64'(busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
